wr_ingress: RTL and testbench
=============================

WR_INGRESS -- requirements
Module: wr_ingress

Interface
REQ-001 Parameters SHALL be: ADDR_SIZE, default 4, FIFO address width; DATA_SIZE, default 8, word width; AF_THRESH, default 12, almost-full level.
REQ-002 wr_clk  input  1  write-domain clock, the only clock; all state updates on posedge.
REQ-003 wr_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_ready  output  1  block can accept a word; registered.
REQ-006 in_data  input  DATA_SIZE  upstream word.
REQ-007 wr_full  input  1  registered full flag from the write-full stage.
REQ-008 wr_ptr  input  ADDR_SIZE+1  write pointer, Gray, from the write-full stage.
REQ-009 wr_q2_rptr  input  ADDR_SIZE+1  read pointer, Gray, already 2-flop synchronised into wr_clk.
REQ-010 wr_inc  output  1  write strobe to the write-full stage and the memory.
REQ-011 wr_data  output  DATA_SIZE  word written to the memory at wr_addr when wr_inc=1.
REQ-012 wr_level  output  ADDR_SIZE+1  FIFO occupancy seen from the write side.
REQ-013 wr_almost_full  output  1  wr_level >= AF_THRESH.

Function
REQ-014 The block SHALL hold a 2-entry in-order skid buffer with occupancy count cnt in 0..2.
REQ-015 Accept: acc = in_valid & in_ready; the accepted word goes to the tail.
REQ-016 Pop: wr_inc = (cnt != 0) & ~wr_full, combinational; wr_data = head entry in the same cycle.
REQ-017 Simultaneous acc and pop SHALL leave cnt unchanged and preserve word order.
REQ-018 cnt_next = cnt + acc - wr_inc; in_ready SHALL register (cnt_next < 2).
REQ-019 Words SHALL never be dropped or duplicated; data in the buffer stays stable while wr_full=1.
REQ-020 Accept-to-wr_inc latency SHALL be 1 cycle when the buffer is empty and wr_full=0.
REQ-021 wr_full does not deassert for at least one cycle after the filling write; wr_inc SHALL obey wr_full as sampled and does not predict full.
REQ-022 wr_level SHALL be registered: gray2bin(wr_ptr) - gray2bin(wr_q2_rptr), modulo 2^(ADDR_SIZE+1), giving 1 cycle latency.
REQ-023 The wr_level range is 0..2^ADDR_SIZE; pointer wrap past the MSB SHALL yield the correct modular difference.
REQ-024 wr_almost_full SHALL be registered from the same next-level value as wr_level, so the two are cycle-aligned.

Reset
REQ-025 While wr_rst_n=0: cnt=0, buffer pointers=0, in_ready=0, wr_level=0, wr_almost_full=0.
REQ-026 While wr_rst_n=0: wr_inc=0 follows from cnt=0.
REQ-027 Reset mid-operation SHALL discard buffered words.
REQ-028 The first in_ready=1 SHALL occur on the first posedge after wr_rst_n rises.

Configuration
REQ-029 Macro WR_INGRESS_LEVEL_EN defined: wr_level and wr_almost_full SHALL be generated per REQ-022..024.
REQ-030 Macro not defined: the ports SHALL remain, tied to 0, with no gray2bin instances or level registers.

Structure
REQ-031 Shared package fifo_pkg SHALL hold the ADDR_SIZE/DATA_SIZE defaults, the ptr_t/level_t widths, and the skid depth constant SKID_DEPTH=2.
REQ-032 Sub-module gray2bin, parameterised by width, SHALL be instantiated twice (wr_ptr and wr_q2_rptr).

Verification
REQ-033 Reset release, in_valid=1, data 0x11,0x22,0x33 back-to-back with wr_full=0 -> in_ready=1 from the first posedge; wr_inc pulses carry 0x11,0x22,0x33 in order, each 1 cycle after acceptance.
REQ-034 Hold wr_full=1 for 5 cycles while pushing 0xA0..0xA3 -> only 2 words accepted; in_ready=0 afterwards; wr_inc=0 throughout.
REQ-035 Release wr_full in the REQ-034 case -> 0xA0,0xA1 are written, then 0xA2,0xA3 accepted; no loss or duplication.
REQ-036 Level with wr_ptr=Gray(13), wr_q2_rptr=Gray(1) -> next cycle wr_level=12, wr_almost_full=1.
REQ-037 Level wrap with wr_ptr=Gray(3), wr_q2_rptr=Gray(30) -> wr_level=5, wr_almost_full=0.
REQ-038 Full-boundary level with wr_ptr=Gray(16), wr_q2_rptr=Gray(0) -> wr_level=16.
REQ-039 Assert wr_rst_n=0 with cnt=2 -> in_ready, wr_inc, wr_level, wr_almost_full are 0 immediately.
REQ-040 After the REQ-039 reset -> the buffer is empty after release.
REQ-041 Build without WR_INGRESS_LEVEL_EN and rerun REQ-036 -> wr_level=0 and wr_almost_full=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default sizes, pointer/level types, skid depth.
// No ports; imported by wr_ingress and gray2bin.
package fifo_pkg;

  localparam int unsigned ADDR_SIZE_DEF = 4;
  localparam int unsigned DATA_SIZE_DEF = 8;
  localparam int unsigned SKID_DEPTH    = 2;
  localparam int unsigned PTR_W         = ADDR_SIZE_DEF + 1;

  // Gray/binary pointer and occupancy types at the default address width.
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W-1:0] level_t;

endpackage

// File: rtl/wr_ingress_gray2bin.sv
// gray2bin: combinational Gray-to-binary converter, width W.
// Ports:
//   gray  [W-1:0]  Gray-coded input
//   bin_c [W-1:0]  binary result (combinational)
module gray2bin
  import fifo_pkg::*;
#(
  parameter int unsigned W = PTR_W
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin_c
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_c = '0;
    for (int unsigned i = 0; i < W; i++) begin
      bin_c[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/wr_ingress.sv
// wr_ingress: write-side ingress of an async FIFO. A 2-entry in-order skid
// buffer decouples the upstream valid/ready handshake from the write-full
// stage; optionally reports the write-side occupancy.
// Optional feature macro: WR_INGRESS_LEVEL_EN (level / almost-full outputs).
// Ports:
//   wr_clk, wr_rst_n   clock, async active-low reset
//   in_valid, in_data  upstream word; in_ready (registered) accepts it
//   wr_full            registered full flag from the write-full stage
//   wr_ptr, wr_q2_rptr Gray write pointer and synchronised Gray read pointer
//   wr_inc, wr_data    write strobe and word to memory (combinational)
//   wr_level           registered occupancy (0 when feature disabled)
//   wr_almost_full     registered wr_level >= AF_THRESH (0 when disabled)
module wr_ingress
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned AF_THRESH = 12
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 wr_full,
  input  logic [ADDR_SIZE:0]   wr_ptr,
  input  logic [ADDR_SIZE:0]   wr_q2_rptr,
  output logic                 wr_inc,
  output logic [DATA_SIZE-1:0] wr_data,
  output logic [ADDR_SIZE:0]   wr_level,
  output logic                 wr_almost_full
);

  localparam int unsigned PW      = ADDR_SIZE + 1;
  localparam int unsigned SKID_AW = $clog2(SKID_DEPTH);
  localparam int unsigned CNT_W   = $clog2(SKID_DEPTH + 1);

  logic [DATA_SIZE-1:0] skid_mem [SKID_DEPTH];
  logic [SKID_AW-1:0]   head;
  logic [SKID_AW-1:0]   tail;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_next;
  logic                 acc;

  // Handshake and drain: the head word leaves whenever the FIFO is not full.
  assign acc     = in_valid & in_ready;
  assign wr_inc  = (cnt != '0) & ~wr_full;
  assign wr_data = skid_mem[head];

  always_comb begin
    cnt_next = cnt + CNT_W'(acc) - CNT_W'(wr_inc);
  end

  // Skid storage; payload needs no reset, cnt qualifies it.
  always_ff @(posedge wr_clk) begin
    if (acc) begin
      skid_mem[tail] <= in_data;
    end
  end

  // Occupancy, ring pointers and registered ready.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      cnt      <= '0;
      head     <= '0;
      tail     <= '0;
      in_ready <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      in_ready <= (cnt_next < CNT_W'(SKID_DEPTH));
      if (acc) begin
        tail <= (tail == SKID_AW'(SKID_DEPTH - 1)) ? '0 : tail + SKID_AW'(1);
      end
      if (wr_inc) begin
        head <= (head == SKID_AW'(SKID_DEPTH - 1)) ? '0 : head + SKID_AW'(1);
      end
    end
  end

`ifdef WR_INGRESS_LEVEL_EN
  logic [PW-1:0] ptr_bin;
  logic [PW-1:0] rptr_bin;
  logic [PW-1:0] level_next;

  gray2bin #(.W(PW)) u_g2b_wptr (
    .gray  (wr_ptr),
    .bin_c (ptr_bin)
  );

  gray2bin #(.W(PW)) u_g2b_rptr (
    .gray  (wr_q2_rptr),
    .bin_c (rptr_bin)
  );

  // Modular subtraction handles pointer wrap past the MSB.
  always_comb begin
    level_next = ptr_bin - rptr_bin;
  end

  // Level and almost-full share level_next so they stay cycle-aligned.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_level       <= '0;
      wr_almost_full <= 1'b0;
    end else begin
      wr_level       <= level_next;
      wr_almost_full <= (level_next >= PW'(AF_THRESH));
    end
  end
`else
  logic unused_level_in;

  assign unused_level_in = ^{wr_ptr, wr_q2_rptr};
  assign wr_level        = '0;
  assign wr_almost_full  = 1'b0;
`endif

endmodule

// File: tb/tb_wr_ingress.sv
// Testbench for wr_ingress: directed stimulus, queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_wr_ingress;

  logic       wr_clk = 1'b0;
  logic       wr_rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       wr_full;
  logic [4:0] wr_ptr;
  logic [4:0] wr_q2_rptr;
  logic       wr_inc;
  logic [7:0] wr_data;
  logic [4:0] wr_level;
  logic       wr_almost_full;

  int total = 0;
  int bad   = 0;

  wr_ingress #(.ADDR_SIZE(4), .DATA_SIZE(8), .AF_THRESH(12)) dut (
    .wr_clk         (wr_clk),
    .wr_rst_n       (wr_rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .wr_full        (wr_full),
    .wr_ptr         (wr_ptr),
    .wr_q2_rptr     (wr_q2_rptr),
    .wr_inc         (wr_inc),
    .wr_data        (wr_data),
    .wr_level       (wr_level),
    .wr_almost_full (wr_almost_full)
  );

  always #5 wr_clk = ~wr_clk;

`ifdef WR_INGRESS_LEVEL_EN
  localparam bit LVL_ON = 1'b1;
`else
  localparam bit LVL_ON = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] gray(input int n);
    return 5'(n ^ (n >> 1));
  endfunction

  // Gray decode by search: the binary value whose Gray code matches.
  function automatic int ungray(input logic [4:0] g);
    for (int n = 0; n < 32; n++) begin
      if (gray(n) == g) return n;
    end
    return -1;
  endfunction

  // Reference model: ordered queue of buffered words, capacity 2.
  logic [7:0] mq[$];
  bit         m_ready = 1'b0;
  int         m_level = 0;
  bit         m_af    = 1'b0;

  initial begin
    forever begin
      @(posedge wr_clk or negedge wr_rst_n);
      if (!wr_rst_n) begin
        mq.delete();
        m_ready = 1'b0;
        m_level = 0;
        m_af    = 1'b0;
      end else begin
        bit pop;
        bit take;
        int lv;
        pop  = (mq.size() != 0) && !wr_full;
        take = in_valid && m_ready;
        if (pop) void'(mq.pop_front());
        if (take) mq.push_back(in_data);
        m_ready = (mq.size() < 2);
        lv      = (ungray(wr_ptr) - ungray(wr_q2_rptr) + 32) % 32;
        m_level = LVL_ON ? lv : 0;
        m_af    = LVL_ON && (lv >= 12);
      end
    end
  end

  // Every-cycle comparison against the model; also logs written words.
  logic [7:0] wlog[$];

  initial begin
    forever begin
      bit exp_inc;
      @(negedge wr_clk);
      exp_inc = wr_rst_n && (mq.size() != 0) && !wr_full;
      chk("in_ready", int'(in_ready), int'(m_ready));
      chk("wr_inc", int'(wr_inc), int'(exp_inc));
      if (exp_inc) chk("wr_data", int'(wr_data), int'(mq[0]));
      chk("wr_level", int'(wr_level), m_level);
      chk("wr_almost_full", int'(wr_almost_full), int'(m_af));
      if (wr_inc && wr_rst_n) wlog.push_back(wr_data);
    end
  end

  // Source words and how many have been accepted.
  logic [7:0] src[$];
  int         idx = 0;

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      bit take;
      if (idx < src.size()) begin
        in_valid = 1'b1;
        in_data  = src[idx];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge wr_clk);
      take = in_valid && in_ready;
      @(posedge wr_clk);
      #1;
      if (take) idx++;
    end
    in_valid = 1'b0;
  endtask

  task automatic set_src(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d, input int n);
    src.delete();
    if (n > 0) src.push_back(a);
    if (n > 1) src.push_back(b);
    if (n > 2) src.push_back(c);
    if (n > 3) src.push_back(d);
    idx = 0;
  endtask

  task automatic level_case(input int wp, input int rp, input int exp_lv, input bit exp_af);
    wr_ptr     = gray(wp);
    wr_q2_rptr = gray(rp);
    @(posedge wr_clk);
    #1;
    chk("lit_level", int'(wr_level), LVL_ON ? exp_lv : 0);
    chk("lit_af", int'(wr_almost_full), int'(LVL_ON && exp_af));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    wr_rst_n   = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    wr_full    = 1'b0;
    wr_ptr     = '0;
    wr_q2_rptr = '0;
    repeat (2) @(posedge wr_clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_wr_inc", int'(wr_inc), 0);
    chk("rst_level", int'(wr_level), 0);

    // Back-to-back 0x11,0x22,0x33 out of reset.
    set_src(8'h11, 8'h22, 8'h33, 8'h00, 3);
    wlog.delete();
    wr_rst_n = 1'b1;
    run(1);
    chk("first_ready", int'(in_ready), 1);
    run(1);
    chk("lat1_inc", int'(wr_inc), 1);
    chk("lat1_data", int'(wr_data), 8'h11);
    run(4);
    chk("b2b_accepted", idx, 3);
    chk("b2b_count", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("b2b_w0", int'(wlog[0]), 8'h11);
      chk("b2b_w1", int'(wlog[1]), 8'h22);
      chk("b2b_w2", int'(wlog[2]), 8'h33);
    end

    // Full back-pressure: only two words fit, nothing written.
    set_src(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4);
    wlog.delete();
    wr_full = 1'b1;
    run(5);
    chk("full_accepted", idx, 2);
    chk("full_ready", int'(in_ready), 0);
    chk("full_inc", int'(wr_inc), 0);
    chk("full_writes", wlog.size(), 0);

    // Release full: all four drain in order.
    wr_full = 1'b0;
    run(8);
    chk("rel_accepted", idx, 4);
    chk("rel_count", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("rel_w0", int'(wlog[0]), 8'hA0);
      chk("rel_w1", int'(wlog[1]), 8'hA1);
      chk("rel_w2", int'(wlog[2]), 8'hA2);
      chk("rel_w3", int'(wlog[3]), 8'hA3);
    end

    // Level cases: threshold, wrap, full boundary.
    level_case(13, 1, 12, 1'b1);
    level_case(3, 30, 5, 1'b0);
    level_case(16, 0, 16, 1'b1);

    // Reset with a full skid buffer.
    set_src(8'hC0, 8'hC1, 8'h00, 8'h00, 2);
    wr_full = 1'b1;
    run(3);
    chk("pre_rst_accepted", idx, 2);
    #1;
    wr_rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", int'(in_ready), 0);
    chk("mid_rst_inc", int'(wr_inc), 0);
    chk("mid_rst_level", int'(wr_level), 0);
    chk("mid_rst_af", int'(wr_almost_full), 0);
    @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
    wr_full  = 1'b0;
    wlog.delete();
    run(3);
    chk("post_rst_inc", int'(wr_inc), 0);
    chk("post_rst_writes", wlog.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
